// File: rtl/spi_shift_ctrl.sv
// SPI master shift engine: drives cs/mosi and assembles rx_data from miso,
// following the serial clock supplied by the upstream clock generator.
module spi_shift_ctrl #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              cpol,
  input  logic              cpha,
  input  logic              lsb_first,
  input  logic              sclk,
  input  logic              miso,
  output logic              cs,
  output logic              mosi,
  output logic [DATA_W-1:0] rx_data,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_XFER,
    S_FINISH,
    S_DONE
  } state_t;

  state_t            state_q;
  logic              sclk_q;     // sclk delayed one clk, used for edge detection
  logic              cpol_q;
  logic              cpha_q;
  logic              lsb_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] tx_sr_q;
  logic [DATA_W-1:0] rx_sr_q;
  logic [DATA_W-1:0] rx_data_q;
  logic              cs_q;
  logic              mosi_q;
  logic              busy_q;
  logic              done_q;

  logic              sclk_chg;
  logic              lead;
  logic              trail;
  logic              last_bit;
  logic              go_done;
  logic [DATA_W-1:0] tx_shift;
  logic [DATA_W-1:0] rx_shift;
  logic [DATA_W-1:0] rx_word;

  function automatic logic head_bit(input logic [DATA_W-1:0] w, input logic lsb);
    return lsb ? w[0] : w[DATA_W-1];
  endfunction

  // Received bits always enter at bit 0; LSB-first frames need reversing.
  function automatic logic [DATA_W-1:0] bit_order(input logic [DATA_W-1:0] w, input logic lsb);
    logic [DATA_W-1:0] r;
    r = w;
    if (lsb) begin
      for (int i = 0; i < DATA_W; i++) r[i] = w[DATA_W-1-i];
    end
    return r;
  endfunction

  assign sclk_chg = (sclk != sclk_q);
  assign lead     = sclk_chg && (sclk_q == cpol_q);
  assign trail    = sclk_chg && (sclk == cpol_q);
  assign last_bit = (cnt_q == CNT_W'(DATA_W - 1));
  assign tx_shift = lsb_q ? {1'b0, tx_sr_q[DATA_W-1:1]} : {tx_sr_q[DATA_W-2:0], 1'b0};
  assign rx_shift = {rx_sr_q[DATA_W-2:0], miso};
  // With cpha=1 the final sample and the frame end coincide, so use the live word.
  assign rx_word  = cpha_q ? rx_shift : rx_sr_q;
  assign go_done  = ((state_q == S_XFER) && cpha_q && trail && last_bit) ||
                    ((state_q == S_FINISH) && trail);

  // NOTE: every register, shift registers included, is cleared asynchronously so an
  // aborted frame leaves no partial word behind; state uses <= so all updates see pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      sclk_q    <= 1'b0;
      cpol_q    <= 1'b0;
      cpha_q    <= 1'b0;
      lsb_q     <= 1'b0;
      cnt_q     <= '0;
      tx_sr_q   <= '0;
      rx_sr_q   <= '0;
      rx_data_q <= '0;
      cs_q      <= 1'b1;
      mosi_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      sclk_q <= sclk;
      case (state_q)
        S_IDLE: begin
          cs_q   <= 1'b1;
          mosi_q <= 1'b0;
          busy_q <= 1'b0;
          if (start) begin
            tx_sr_q <= tx_data;
            cpol_q  <= cpol;
            cpha_q  <= cpha;
            lsb_q   <= lsb_first;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (sclk == cpol_q && sclk_q == cpol_q) begin
            cs_q <= 1'b0;
            if (!cpha_q) mosi_q <= head_bit(tx_sr_q, lsb_q);
            state_q <= S_XFER;
          end
        end
        S_XFER: begin
          if (!cpha_q) begin
            if (lead) begin
              rx_sr_q <= rx_shift;
              cnt_q   <= cnt_q + CNT_W'(1);
              if (last_bit) state_q <= S_FINISH;
            end else if (trail) begin
              tx_sr_q <= tx_shift;
              mosi_q  <= head_bit(tx_shift, lsb_q);
            end
          end else begin
            if (lead) begin
              mosi_q  <= head_bit(tx_sr_q, lsb_q);
              tx_sr_q <= tx_shift;
            end else if (trail) begin
              rx_sr_q <= rx_shift;
              cnt_q   <= cnt_q + CNT_W'(1);
            end
          end
        end
        S_FINISH: ;
        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase

      if (go_done) begin
        cs_q      <= 1'b1;
        mosi_q    <= 1'b0;
        rx_data_q <= bit_order(rx_word, lsb_q);
        done_q    <= 1'b1;
        state_q   <= S_DONE;
      end
    end
  end

  assign cs      = cs_q;
  assign mosi    = mosi_q;
  assign rx_data = rx_data_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_spi_shift_ctrl.sv
// Bench for spi_shift_ctrl: models the clock generator and an SPI slave, and
// scores every completed frame against the words the slave sent and received.
module tb_spi_shift_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] tx_data;
  logic         cpol;
  logic         cpha;
  logic         lsb_first;
  logic         sclk;
  logic         miso;
  logic         cs;
  logic         mosi;
  logic [W-1:0] rx_data;
  logic         busy;
  logic         done;

  typedef struct {
    logic [W-1:0] rx;
    logic [W-1:0] tx;
    logic         pol;
  } exp_t;

  exp_t         sb[$];
  exp_t         e;
  int           total = 0;
  int           bad   = 0;

  // Generator and slave model state
  logic         sclk_g  = 1'b0;
  int           half    = 1;
  int           hcnt    = 0;
  int           lag     = 0;
  bit           cpol_t  = 1'b0;
  bit           cpha_t  = 1'b0;
  bit           lsb_t   = 1'b0;
  bit           loop_t  = 1'b0;
  logic [W-1:0] slave_w = '0;
  logic [W-1:0] cap     = '0;
  int           nsamp   = 0;
  int           sidx    = 0;
  bit           adv     = 1'b0;
  bit           prev_cs = 1'b1;
  bit           lead_e  = 1'b0;
  logic         miso_s  = 1'b0;
  int           ndone   = 0;
  bit           done_prev = 1'b0;

  assign sclk = sclk_g;
  assign miso = loop_t ? mosi : miso_s;

  spi_shift_ctrl #(.DATA_W(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .tx_data  (tx_data),
    .cpol     (cpol),
    .cpha     (cpha),
    .lsb_first(lsb_first),
    .sclk     (sclk),
    .miso     (miso),
    .cs       (cs),
    .mosi     (mosi),
    .rx_data  (rx_data),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic sbit(input int j);
    if (j >= W) return 1'b0;
    return lsb_t ? slave_w[j] : slave_w[W-1-j];
  endfunction

  // Clock generator: parks sclk at the cpol input (after a few cycles) while cs is high,
  // toggles every `half` clk while cs is low. The slave shares this process.
  always @(negedge clk) begin
    if (cs !== 1'b0) begin
      hcnt    = 0;
      prev_cs = 1'b1;
      if (sclk_g != cpol) begin
        lag++;
        if (lag >= 4) begin
          sclk_g = cpol;
          lag    = 0;
        end
      end else begin
        lag = 0;
      end
    end else begin
      if (prev_cs) begin
        prev_cs = 1'b0;
        nsamp   = 0;
        sidx    = 0;
        cap     = '0;
        adv     = 1'b0;
        miso_s  = sbit(0);
      end else if (adv) begin
        adv    = 1'b0;
        sidx++;
        miso_s = sbit(sidx);
      end
      hcnt++;
      if (hcnt >= half) begin
        hcnt   = 0;
        lead_e = (sclk_g == cpol_t);
        sclk_g = ~sclk_g;
        if (lead_e != cpha_t) begin
          if (nsamp < W) cap[lsb_t ? nsamp : W-1-nsamp] = mosi;
          nsamp++;
          adv = 1'b1;
        end
      end
    end
  end

  // Monitor: scores each done pulse against the oldest outstanding request.
  always @(negedge clk) begin
    if (done_prev) begin
      check("busy_after_done", busy, 0);
      check("done_single_cycle", done, 0);
      done_prev = 1'b0;
    end
    if (done === 1'b1) begin
      ndone++;
      done_prev = 1'b1;
      check("pending_request", sb.size() > 0, 1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("rx_data", rx_data, e.rx);
        check("mosi_word", cap, e.tx);
        check("sample_count", nsamp, W);
        check("sclk_idle_at_cs_rise", sclk, e.pol);
        check("cs_at_done", cs, 1);
        check("busy_at_done", busy, 1);
      end
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    if (n >= 500) check("idle_timeout", busy, 0);
  endtask

  task automatic issue(input logic [W-1:0] tx, input bit pol, input bit pha, input bit lsb,
                       input bit lp, input logic [W-1:0] sw, input int hp);
    wait_idle();
    @(posedge clk); #1;
    tx_data   = tx;
    cpol      = pol;
    cpha      = pha;
    lsb_first = lsb;
    start     = 1'b1;
    cpol_t    = pol;
    cpha_t    = pha;
    lsb_t     = lsb;
    loop_t    = lp;
    slave_w   = sw;
    half      = hp;
    nsamp     = 0;
    sb.push_back('{rx: (lp ? tx : sw), tx: tx, pol: pol});
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done();
    int n0;
    int n;
    n0 = ndone;
    n  = 0;
    while (ndone == n0 && n < 400) begin
      @(posedge clk);
      n++;
    end
    check("done_seen", ndone != n0, 1);
  endtask

  task automatic wait_samples(input int k);
    int n;
    n = 0;
    while (nsamp < k && n < 400) begin
      @(posedge clk);
      n++;
    end
    check("samples_reached", nsamp >= k, 1);
  endtask

  initial begin
    int n0;
    rst       = 1'b1;
    start     = 1'b0;
    tx_data   = '0;
    cpol      = 1'b0;
    cpha      = 1'b0;
    lsb_first = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_cs", cs, 1);
    check("reset_mosi", mosi, 0);
    check("reset_rx_data", rx_data, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    rst = 1'b0;

    // Mode 0 loopback, fastest clock
    issue(8'hA5, 0, 0, 0, 1, 8'h00, 1);
    wait_done();
    // Mode 3 with miso tied high
    issue(8'h3C, 1, 1, 0, 0, 8'hFF, 1);
    wait_done();
    // LSB first, mode 1, loopback
    issue(8'h01, 0, 1, 1, 1, 8'h00, 2);
    wait_done();

    // cpol flips one cycle before start: cs must stay high until sclk settles
    wait_idle();
    @(posedge clk); #1;
    cpol = 1'b1;
    issue(8'h6B, 1, 0, 0, 1, 8'h00, 1);
    @(negedge clk);
    @(negedge clk);
    check("setup_hold_1", cs, 1);
    @(negedge clk);
    check("setup_hold_2", cs, 1);
    wait_done();

    // start re-pulsed mid-transfer is ignored
    n0 = ndone;
    issue(8'h96, 0, 0, 0, 1, 8'h00, 2);
    wait_samples(2);
    @(posedge clk); #1;
    tx_data = 8'hFF;
    start   = 1'b1;
    @(posedge clk); #1;
    start   = 1'b0;
    wait_done();
    repeat (60) @(posedge clk);
    check("single_done_on_restart", ndone - n0, 1);

    // Reset after three bits
    issue(8'hC3, 0, 0, 0, 1, 8'h00, 2);
    wait_samples(3);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("abort_cs", cs, 1);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_rx_data", rx_data, 0);
    check("abort_mosi", mosi, 0);
    sb.delete();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    issue(8'h5A, 0, 0, 0, 1, 8'h00, 1);
    wait_done();

    // Random frames with independent slave data and mid-frame input churn
    for (int i = 0; i < 40; i++) begin
      issue(W'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), W'($urandom),
            $urandom_range(1, 3));
      @(posedge clk); #1;
      tx_data   = W'($urandom);
      cpha      = 1'($urandom_range(0, 1));
      lsb_first = 1'($urandom_range(0, 1));
      start     = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      start     = 1'b0;
      wait_done();
    end

    repeat (20) @(posedge clk);
    check("scoreboard_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
